key_step_scheduler: RTL and testbench
=====================================

# key_step_scheduler

Turns the held-arrow-key vector from the keyboard controller into a paced stream of single-square move requests for the game logic. Each new press produces one step immediately, then auto-repeats after an initial delay at a fixed repeat rate. Simultaneous directions are shared round-robin over one valid/ready step channel. The block sits between `keyboard_controller` and the square-movement logic, in the `clk_50` domain.

## Interface

Parameters:
- `DELAY_CYCLES`, 12_500_000: cycles from a press to the first auto-repeat (250 ms at 50 MHz); must be ≥ 2.
- `REPEAT_CYCLES`, 2_500_000: cycles between auto-repeats (50 ms); must be ≥ 2.
- `CNT_W`, 24: timer width; must hold max(DELAY_CYCLES, REPEAT_CYCLES)-1.

Ports:
- `clk_50`  in  1  system clock; the block has exactly one clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `keys`  in  4  held keys, synchronous to `clk_50`: bit0 up, bit1 down, bit2 right, bit3 left.
- `enable`  in  1  game running; when low, no steps are requested.
- `step_valid`  out  1  step request pending.
- `step_dir`  out  2  direction code: 0 up, 1 down, 2 right, 3 left (matches `keys` bit index).
- `step_ready`  in  1  consumer accepts the step.
- `repeating`  out  1  high while the timer is in the REPEAT state.

## Operation

- `keys_q` registers `keys` every cycle, independent of `enable`. Press edges are `keys & ~keys_q`.
- `pend[3:0]` holds outstanding requests, one bit per direction.
  - A press edge sets its bit.
  - A timer expiry sets `pend |= keys`.
  - Bits persist after key release until accepted; a tap always yields exactly one step.
- Timer FSM (`state`, `timer`):
  - IDLE: timer = 0. Any press edge → DELAY, load `DELAY_CYCLES-1`.
  - DELAY: decrement each cycle. At `timer==0`, set `pend |= keys` → REPEAT, load `REPEAT_CYCLES-1`.
  - REPEAT: decrement each cycle. At `timer==0`, set `pend |= keys` and reload `REPEAT_CYCLES-1`.
  - From any state, `keys==0` → IDLE (this takes priority over expiry).
  - Any press edge in DELAY or REPEAT → DELAY, reload `DELAY_CYCLES-1`. This takes priority over expiry. If both occur in the same cycle, `pend` still gets `keys`.
- Arbiter:
  - `ptr[1:0]` is the round-robin start.
  - When `step_valid==0` and `pend!=0`, the first set bit scanning `ptr, ptr+1, …` (mod 4) is registered into `step_dir`, and `step_valid` is set.
  - `step_valid` and `step_dir` hold stable until accepted.
  - Accept happens on `step_valid && step_ready`. On accept: clear `pend[step_dir]`, set `ptr = step_dir+1` (wraps 3→0), and drop `step_valid`.
  - If a set and a clear hit the same `pend` bit in the same cycle, set wins.
- Opposing keys (up+down) are not cancelled; each is served in turn.
- `enable` low:
  - clears `pend` and `step_valid`,
  - forces IDLE and `timer = 0`,
  - ignores press edges.
  - `ptr` and `keys_q` are kept.
  - Keys already held when `enable` rises produce no step until released and pressed again.
- Reset values: `step_valid` 0, `step_dir` 0, `repeating` 0, `pend` 0, `ptr` 0, `keys_q` 0, state IDLE, `timer` 0.
- A reset mid-operation discards all pending steps, including a presented but unaccepted step.

## Timing

- Press sampled at edge k: `pend` bit set at edge k. `step_valid` is high after edge k+1 (2-cycle latency from `keys` change to valid).
- First repeat `pend` set at edge k+DELAY_CYCLES. Subsequent repeats at k+DELAY_CYCLES+n·REPEAT_CYCLES.
- After an accept at edge m, `step_valid` is low for at least cycle m..m+1. The next grant is presented after edge m+1. Maximum throughput is one step per 2 cycles.
- `step_dir` never changes while `step_valid` is high.
- No combinational path from any input to any output.

## Test plan

Use DELAY_CYCLES=10 and REPEAT_CYCLES=4 with `step_ready` tied high unless stated.

- Reset/tap: hold `rst` → all outputs 0. Then pulse `keys`=0001 for 1 cycle → exactly one step with dir 0, `step_valid` high 2 cycles after the press, `repeating` stays 0.
- Hold right: `keys`=0100 held 30 cycles from edge k → pends at k, k+10, k+14, k+18, k+22, k+26 give 6 steps of dir 2. `repeating` high from k+10 until release.
- Round-robin under backpressure:
  - Setup: `step_ready`=0, press up+left together.
  - Expected: `step_valid` held with dir 0.
  - Then: raise `step_ready`.
  - Expected: accept dir 0, then dir 3 next. No dir change while stalled.
- Re-press restarts delay: hold up, press down at k+7 → no expiry at k+10. Next repeat pend at k+7+10 for both up and down.
- Enable gating: keys held, drop `enable` mid-REPEAT with a step stalled → `step_valid` 0 next cycle, `pend` cleared. Raise `enable` with keys still held → no steps until a new press.
- Async reset mid-DELAY with `step_valid` high → outputs 0 immediately, without waiting for a clock edge. After release, no step until a new press edge.

Source files
------------

// File: rtl/key_step_scheduler.sv
// key_step_scheduler
//
// Turns the held-arrow-key vector from keyboard_controller into a paced stream
// of single-square move requests. A new press yields one step right away. Held
// keys then auto-repeat after DELAY_CYCLES, and every REPEAT_CYCLES after that.
// Several held directions share one valid/ready channel round-robin.
//
// Ports
//   clk_50      in   system clock (the only clock)
//   rst         in   asynchronous, active-high reset
//   keys[3:0]   in   held keys: bit0 up, bit1 down, bit2 right, bit3 left
//   enable      in   game running; low clears pending work and ignores presses
//   step_valid  out  a step request is being presented
//   step_dir    out  direction of the presented step (same index as keys)
//   step_ready  in   consumer accepts the presented step
//   repeating   out  high while the timer is in its auto-repeat phase
//
// Every output comes straight from a register, so no input reaches an output
// combinationally.

module key_step_scheduler #(
    parameter int DELAY_CYCLES  = 12_500_000,
    parameter int REPEAT_CYCLES = 2_500_000,
    parameter int CNT_W         = 24
) (
    input  logic       clk_50,
    input  logic       rst,
    input  logic [3:0] keys,
    input  logic       enable,
    output logic       step_valid,
    output logic [1:0] step_dir,
    input  logic       step_ready,
    output logic       repeating
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_next;
    logic [3:0]       keys_q;
    logic [3:0]       pend;
    logic [3:0]       press;
    logic [3:0]       set_mask;
    logic [3:0]       clr_mask;
    logic [1:0]       ptr;
    logic [1:0]       grant_dir;
    logic             expire;
    logic             accept;

    // Press edges are only meaningful while the game runs. keys_q keeps
    // tracking while disabled, so keys held across enable rising do not
    // count as new presses.
    assign press  = enable ? (keys & ~keys_q) : 4'b0000;
    assign accept = step_valid & step_ready;

    assign repeating = (state == REPEAT);

    // Timer state register.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    // Next-state logic. Releasing every key wins over expiry. A fresh press
    // restarts the initial delay, but an expiry that lands on the same cycle
    // still re-arms the held keys.
    always_comb begin
        state_next = state;
        timer_next = timer;
        expire     = 1'b0;
        if (!enable || (keys == 4'b0000)) begin
            state_next = IDLE;
            timer_next = '0;
        end else begin
            if ((state != IDLE) && (timer == '0)) begin
                expire = 1'b1;
            end
            if (press != 4'b0000) begin
                state_next = DELAY;
                timer_next = DELAY_LOAD;
            end else if (state != IDLE) begin
                if (timer == '0) begin
                    state_next = REPEAT;
                    timer_next = REPEAT_LOAD;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
        end
    end

    // Requests raised this cycle and the one retired by an accept. When both
    // hit the same bit, the set is applied last and wins.
    always_comb begin
        set_mask = press | (expire ? keys : 4'b0000);
        clr_mask = accept ? (4'b0001 << step_dir) : 4'b0000;
    end

    // Round-robin pick: the first pending direction found when scanning
    // from ptr upward, wrapping 3 -> 0.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        found     = 1'b0;
        idx       = ptr;
        grant_dir = ptr;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && pend[idx]) begin
                grant_dir = idx;
                found     = 1'b1;
            end
        end
    end

    // Pending bits and the step channel. A grant is registered only while
    // the channel is empty, so step_dir cannot change under a stalled
    // request. The pointer moves past whatever was just accepted.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            keys_q     <= 4'b0000;
            pend       <= 4'b0000;
            ptr        <= 2'd0;
            step_valid <= 1'b0;
            step_dir   <= 2'd0;
        end else begin
            keys_q <= keys;
            if (!enable) begin
                pend       <= 4'b0000;
                step_valid <= 1'b0;
            end else begin
                pend <= (pend & ~clr_mask) | set_mask;
                if (accept) begin
                    step_valid <= 1'b0;
                    ptr        <= step_dir + 2'd1;
                end else if (!step_valid && (pend != 4'b0000)) begin
                    step_valid <= 1'b1;
                    step_dir   <= grant_dir;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_step_scheduler.sv
// tb_key_step_scheduler
//
// Directed bench for key_step_scheduler with DELAY_CYCLES=10, REPEAT_CYCLES=4.
// Inputs are driven and outputs sampled on the falling edge of clk_50. A
// monitor logs every accepted step so whole sequences can be compared against
// hand-computed direction lists.

module tb_key_step_scheduler;

    logic       clk_50;
    logic       rst;
    logic [3:0] keys;
    logic       enable;
    logic       step_valid;
    logic [1:0] step_dir;
    logic       step_ready;
    logic       repeating;

    int checks = 0;
    int errors = 0;

    logic [1:0] acc_q[$];
    int         rep_seen    = 0;
    int         dir_changed = 0;
    logic       prev_valid  = 1'b0;
    logic       prev_ready  = 1'b0;
    logic [1:0] prev_dir    = 2'd0;
    logic       any_valid;

    key_step_scheduler #(
        .DELAY_CYCLES (10),
        .REPEAT_CYCLES(4),
        .CNT_W        (8)
    ) dut (
        .clk_50    (clk_50),
        .rst       (rst),
        .keys      (keys),
        .enable    (enable),
        .step_valid(step_valid),
        .step_dir  (step_dir),
        .step_ready(step_ready),
        .repeating (repeating)
    );

    // 50 MHz-style free-running clock.
    initial begin
        clk_50 = 1'b0;
        forever #10 clk_50 = ~clk_50;
    end

    // Logs accepted steps, counts cycles spent repeating, and flags any
    // direction change while a presented step is stalled.
    always @(posedge clk_50) begin
        if (!rst) begin
            if (step_valid && step_ready) begin
                acc_q.push_back(step_dir);
            end
            if (repeating) begin
                rep_seen++;
            end
            if (prev_valid && !prev_ready && step_valid && (step_dir != prev_dir)) begin
                dir_changed++;
            end
        end
        prev_valid = step_valid;
        prev_ready = step_ready;
        prev_dir   = step_dir;
    end

    task automatic applyStimulus(input logic [3:0] k, input logic en, input logic rdy);
        keys       = k;
        enable     = en;
        step_ready = rdy;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_50);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearLog();
        acc_q.delete();
        rep_seen = 0;
    endtask

    // Packs the accepted-direction log, first step in bits [1:0].
    function automatic logic [31:0] logPacked();
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < acc_q.size() && i < 16; i++) begin
            p[2*i +: 2] = acc_q[i];
        end
        return p;
    endfunction

    initial begin
        // Reset state.
        rst = 1'b1;
        applyStimulus(4'b0000, 1'b1, 1'b1);
        waitCycles(3);
        checkOutput("reset_valid", 32'(step_valid), 32'd0);
        checkOutput("reset_dir", 32'(step_dir), 32'd0);
        checkOutput("reset_repeating", 32'(repeating), 32'd0);
        rst = 1'b0;
        waitCycles(2);

        // Single-cycle tap of up.
        $display("[TB] tap");
        clearLog();
        applyStimulus(4'b0001, 1'b1, 1'b1);
        @(negedge clk_50);
        checkOutput("tap_valid_k", 32'(step_valid), 32'd0);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        @(negedge clk_50);
        checkOutput("tap_valid_k1", 32'(step_valid), 32'd1);
        checkOutput("tap_dir", 32'(step_dir), 32'd0);
        @(negedge clk_50);
        checkOutput("tap_valid_after_acc", 32'(step_valid), 32'd0);
        waitCycles(20);
        checkOutput("tap_count", 32'(acc_q.size()), 32'd1);
        checkOutput("tap_log", logPacked(), 32'h0);
        checkOutput("tap_repeating", 32'(rep_seen), 32'd0);

        // Hold right for 30 cycles: pends at k, k+10, k+14, k+18, k+22, k+26.
        $display("[TB] hold right");
        clearLog();
        applyStimulus(4'b0100, 1'b1, 1'b1);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_50);
            if (c == 9)  checkOutput("hold_rep_k9", 32'(repeating), 32'd0);
            if (c == 10) begin
                checkOutput("hold_rep_k10", 32'(repeating), 32'd1);
                checkOutput("hold_valid_k10", 32'(step_valid), 32'd0);
            end
            if (c == 11) checkOutput("hold_valid_k11", 32'(step_valid), 32'd1);
        end
        applyStimulus(4'b0000, 1'b1, 1'b1);
        @(negedge clk_50);
        checkOutput("hold_rep_release", 32'(repeating), 32'd0);
        waitCycles(10);
        checkOutput("hold_count", 32'(acc_q.size()), 32'd6);
        checkOutput("hold_log", logPacked(), 32'hAAA);

        // Round-robin under backpressure, starting from a fresh pointer.
        $display("[TB] round robin");
        rst = 1'b1;
        waitCycles(1);
        rst = 1'b0;
        clearLog();
        applyStimulus(4'b1001, 1'b1, 1'b0);
        @(negedge clk_50);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        @(negedge clk_50);
        checkOutput("rr_valid_k1", 32'(step_valid), 32'd1);
        checkOutput("rr_dir_k1", 32'(step_dir), 32'd0);
        waitCycles(4);
        checkOutput("rr_valid_k5", 32'(step_valid), 32'd1);
        checkOutput("rr_dir_k5", 32'(step_dir), 32'd0);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        @(negedge clk_50);
        checkOutput("rr_valid_after_acc", 32'(step_valid), 32'd0);
        @(negedge clk_50);
        checkOutput("rr_valid_second", 32'(step_valid), 32'd1);
        checkOutput("rr_dir_second", 32'(step_dir), 32'd3);
        waitCycles(4);
        checkOutput("rr_log", logPacked(), 32'hC);
        checkOutput("rr_count", 32'(acc_q.size()), 32'd2);

        // Pressing down at k+7 while up is held restarts the delay.
        $display("[TB] re-press");
        clearLog();
        applyStimulus(4'b0001, 1'b1, 1'b1);
        for (int c = 0; c < 22; c++) begin
            @(negedge clk_50);
            if (c == 6)  applyStimulus(4'b0011, 1'b1, 1'b1);
            if (c == 11) checkOutput("rp_valid_k11", 32'(step_valid), 32'd0);
            if (c == 16) checkOutput("rp_rep_k16", 32'(repeating), 32'd0);
            if (c == 17) begin
                checkOutput("rp_rep_k17", 32'(repeating), 32'd1);
                checkOutput("rp_valid_k17", 32'(step_valid), 32'd0);
            end
            if (c == 18) begin
                checkOutput("rp_valid_k18", 32'(step_valid), 32'd1);
                checkOutput("rp_dir_k18", 32'(step_dir), 32'd0);
            end
            if (c == 19) applyStimulus(4'b0000, 1'b1, 1'b1);
        end
        waitCycles(4);
        checkOutput("rp_count", 32'(acc_q.size()), 32'd4);
        checkOutput("rp_log", logPacked(), 32'h44);

        // Dropping enable mid-repeat with a stalled step.
        $display("[TB] enable gating");
        applyStimulus(4'b0001, 1'b1, 1'b1);
        for (int c = 0; c < 17; c++) begin
            @(negedge clk_50);
            if (c == 10) applyStimulus(4'b0001, 1'b1, 1'b0);
            if (c == 12) begin
                checkOutput("en_valid_stalled", 32'(step_valid), 32'd1);
                checkOutput("en_dir_stalled", 32'(step_dir), 32'd0);
                checkOutput("en_rep_before", 32'(repeating), 32'd1);
                applyStimulus(4'b0001, 1'b0, 1'b0);
            end
            if (c == 13) begin
                checkOutput("en_valid_dropped", 32'(step_valid), 32'd0);
                checkOutput("en_rep_dropped", 32'(repeating), 32'd0);
            end
        end
        applyStimulus(4'b0001, 1'b1, 1'b1);
        clearLog();
        any_valid = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk_50);
            any_valid = any_valid | step_valid;
        end
        checkOutput("en_no_step_held", 32'(any_valid), 32'd0);
        checkOutput("en_no_acc_held", 32'(acc_q.size()), 32'd0);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        @(negedge clk_50);
        applyStimulus(4'b0001, 1'b1, 1'b1);
        waitCycles(2);
        checkOutput("en_repress_valid", 32'(step_valid), 32'd1);
        checkOutput("en_repress_dir", 32'(step_dir), 32'd0);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        waitCycles(3);
        checkOutput("en_repress_count", 32'(acc_q.size()), 32'd1);

        // Asynchronous reset in DELAY with a step presented.
        $display("[TB] async reset");
        applyStimulus(4'b0100, 1'b1, 1'b0);
        waitCycles(2);
        checkOutput("ar_valid_before", 32'(step_valid), 32'd1);
        checkOutput("ar_dir_before", 32'(step_dir), 32'd2);
        @(negedge clk_50);
        rst = 1'b1;
        applyStimulus(4'b0000, 1'b1, 1'b0);
        #1;
        checkOutput("ar_valid_now", 32'(step_valid), 32'd0);
        checkOutput("ar_dir_now", 32'(step_dir), 32'd0);
        checkOutput("ar_rep_now", 32'(repeating), 32'd0);
        @(negedge clk_50);
        rst = 1'b0;
        applyStimulus(4'b0000, 1'b1, 1'b1);
        clearLog();
        any_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_50);
            any_valid = any_valid | step_valid;
        end
        checkOutput("ar_no_step", 32'(any_valid), 32'd0);
        applyStimulus(4'b1000, 1'b1, 1'b1);
        waitCycles(2);
        checkOutput("ar_new_valid", 32'(step_valid), 32'd1);
        checkOutput("ar_new_dir", 32'(step_dir), 32'd3);
        applyStimulus(4'b0000, 1'b1, 1'b1);
        waitCycles(3);
        checkOutput("ar_new_count", 32'(acc_q.size()), 32'd1);

        checkOutput("dir_stable_while_stalled", 32'(dir_changed), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
